// File: rtl/a_plus_b_arb_pkg.sv
// Shared types and helpers for the a_plus_b round-robin arbiter.
//   state_t  : issue FSM states
//   id_width : bit width needed to index n items (never below 1)
package a_plus_b_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_A = 2'd2,
    WAIT_B = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/a_plus_b_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection.
// Searches req starting at index ptr and wrapping around; the first
// requester found wins.
//   req       : request vector
//   ptr       : index holding highest priority this cycle
//   enable    : when low, no grant is produced
//   grant     : one-hot grant
//   grant_idx : binary index of the granted requester
//   any_grant : a grant was produced
module rr_arbiter #(
  parameter int N    = 4,
  parameter int W_ID = 2
) (
  input  logic [N-1:0]    req,
  input  logic [W_ID-1:0] ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [W_ID-1:0] grant_idx,
  output logic            any_grant
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (enable) begin
      for (int off = 0; off < N; off++) begin
        idx = (int'(ptr) + off) % N;
        if (!any_grant && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = W_ID'(idx);
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/a_plus_b_arbiter.sv
// Round-robin scheduler sharing one a_plus_b adder between N_REQ requesters.
// A granted operand pair is registered and offered on the adder's two
// independent operand streams; the requester ID goes into an in-order tag
// queue so each returning sum can be routed back to its issuer.
//   clk, rst                : clock, synchronous active-low reset
//   req_valid/ready/data_a/b: requester operand pairs (packed per requester)
//   op_valid/ready/data_a/b : operand streams to the adder
//   sum_valid/ready/data    : sum stream from the adder
//   rsp_valid/ready/data/id : routed response (rsp_valid one-hot)
//   err_orphan              : sticky flag, sum seen with no tag outstanding
module a_plus_b_arbiter
  import a_plus_b_arb_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter int  W_DATA = 8,
  parameter int  D_TAG  = 8,
  localparam int W_ID   = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W_DATA-1:0] req_data_a,
  input  logic [N_REQ*W_DATA-1:0] req_data_b,
  output logic                    op_valid_a,
  input  logic                    op_ready_a,
  output logic [W_DATA-1:0]       op_data_a,
  output logic                    op_valid_b,
  input  logic                    op_ready_b,
  output logic [W_DATA-1:0]       op_data_b,
  input  logic                    sum_valid,
  output logic                    sum_ready,
  input  logic [W_DATA:0]         sum_data,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [W_DATA:0]         rsp_data,
  output logic [W_ID-1:0]         rsp_id,
  output logic                    err_orphan
);

  localparam int W_PTR = id_width(D_TAG);
  localparam int W_CNT = $clog2(D_TAG + 1);

  state_t            state_q, state_d;
  logic [W_ID-1:0]   ptr_q, ptr_d;
  logic [W_DATA-1:0] op_a_q, op_a_d;
  logic [W_DATA-1:0] op_b_q, op_b_d;
  logic [W_ID-1:0]   tag_mem_q [D_TAG];
  logic [W_ID-1:0]   tag_mem_d [D_TAG];
  logic [W_PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [W_CNT-1:0]  count_q, count_d;
  logic              err_orphan_q, err_orphan_d;

  logic              empty, full;
  logic [W_ID-1:0]   head;
  logic              arb_enable;
  logic [N_REQ-1:0]  grant;
  logic [W_ID-1:0]   grant_idx;
  logic              any_grant;
  logic              push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == W_CNT'(D_TAG));
  assign head  = tag_mem_q[rd_ptr_q];

  // A full queue blocks arbitration outright, even if a sum pops this cycle.
  assign arb_enable = rst && (state_q == IDLE) && !full;

  rr_arbiter #(
    .N    (N_REQ),
    .W_ID (W_ID)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready  = grant;
  assign push       = any_grant;
  assign sum_ready  = rst && !empty && rsp_ready[head];
  assign pop        = sum_valid && sum_ready;
  assign rsp_data   = sum_data;
  assign rsp_id     = head;
  assign op_data_a  = op_a_q;
  assign op_data_b  = op_b_q;
  assign err_orphan = rst && err_orphan_q;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = rst && sum_valid && !empty && (head == W_ID'(i));
    end
  end

  // Issue FSM: each operand stream handshakes independently, so after
  // ISSUE we may still owe one side in WAIT_A or WAIT_B.
  always_comb begin
    state_d    = state_q;
    op_valid_a = 1'b0;
    op_valid_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) state_d = ISSUE;
      end
      ISSUE: begin
        op_valid_a = rst;
        op_valid_b = rst;
        if (op_ready_a && op_ready_b) state_d = IDLE;
        else if (op_ready_a)          state_d = WAIT_B;
        else if (op_ready_b)          state_d = WAIT_A;
      end
      WAIT_A: begin
        op_valid_a = rst;
        if (op_ready_a) state_d = IDLE;
      end
      WAIT_B: begin
        op_valid_b = rst;
        if (op_ready_b) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    ptr_d        = ptr_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q | (sum_valid && empty);

    if (push) begin
      op_a_d              = req_data_a[int'(grant_idx)*W_DATA +: W_DATA];
      op_b_d              = req_data_b[int'(grant_idx)*W_DATA +: W_DATA];
      ptr_d               = (grant_idx == W_ID'(N_REQ - 1)) ? '0 : grant_idx + W_ID'(1);
      tag_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d            = (wr_ptr_q == W_PTR'(D_TAG - 1)) ? '0 : wr_ptr_q + W_PTR'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == W_PTR'(D_TAG - 1)) ? '0 : rd_ptr_q + W_PTR'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + W_CNT'(1);
      2'b01:   count_d = count_q - W_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      tag_mem_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: doc/a_plus_b_arbiter.md
Name: a_plus_b_arbiter

Overview:
Round-robin scheduler that shares one a_plus_b_fifo adder datapath between N_REQ requesters. Each requester offers an operand pair (a, b).
- The arbiter grants one requester at a time and issues the pair onto the adder's two independent operand streams.
- It records the requester ID in an in-order tag queue and routes each returning sum back to the requester that issued it.
- It sits between the requester clients and one a_plus_b_fifo instance.

Parameters:
N_REQ, 4, number of requesters (≥2)
W_DATA, 8, operand width; sum width is W_DATA+1
D_TAG, 8, tag queue depth = max pairs in flight inside the adder path
W_ID, $clog2(N_REQ), localparam, requester ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  N_REQ  per-requester pair valid
req_ready  out  N_REQ  per-requester pair accepted
req_data_a  in  N_REQ*W_DATA  operand a, requester i at bits [i*W_DATA +: W_DATA]
req_data_b  in  N_REQ*W_DATA  operand b, same packing
op_valid_a  out  1  operand a stream to adder
op_ready_a  in  1
op_data_a  out  W_DATA
op_valid_b  out  1  operand b stream to adder
op_ready_b  in  1
op_data_b  out  W_DATA
sum_valid  in  1  sum stream from adder
sum_ready  out  1
sum_data  in  W_DATA+1
rsp_valid  out  N_REQ  one-hot response valid
rsp_ready  in  N_REQ  per-requester response ready
rsp_data  out  W_DATA+1  shared response bus (= sum_data)
rsp_id  out  W_ID  ID of the current tag-queue head
err_orphan  out  1  sticky: sum_valid seen while tag queue empty

Behaviour:
Reset (rst==0 at posedge):
- FSM → IDLE; rr pointer → 0 (requester 0 highest priority first); tag queue emptied; err_orphan → 0; operand registers cleared.
- While rst==0, every output is 0: req_ready, op_valid_*, sum_ready, rsp_valid, err_orphan.
- Mid-operation reset drops the in-flight pair and all tags. The adder instance must share this reset.

Arbitration:
- Round-robin, searched starting at index ptr.
- In IDLE with tag queue not full: req_ready[g]=1 only for the winner g; all other bits are 0.
- On accept:
  - capture req_data_a[g] and req_data_b[g] into the operand registers;
  - push g into the tag queue;
  - ptr ← (g+1) mod N_REQ;
  - FSM → ISSUE.
- req_ready never depends on op_ready_*.

FSM states {IDLE, ISSUE, WAIT_A, WAIT_B}:
- ISSUE: op_valid_a=op_valid_b=1.
  - Both handshake in the same cycle → IDLE.
  - Only a handshakes → WAIT_B.
  - Only b handshakes → WAIT_A.
- WAIT_A: op_valid_a=1, op_valid_b=0; a handshake → IDLE.
- WAIT_B: mirror of WAIT_A.
- op_data_* hold stable while the matching op_valid_* is 1. A valid, once raised, is never dropped before its handshake.

Latency and throughput:
- Accept at cycle t → op_valid_* high at t+1.
- Best case one pair per 2 cycles: accept, then issue, then IDLE.

Tag queue:
- Depth D_TAG circular buffer with count.
- Push is blocked when full, even if a pop occurs the same cycle.
- Pop on sum handshake. Simultaneous push and pop when not full → count unchanged.
- Wrap-around of both pointers at D_TAG-1 → 0.

Response path:
- head = tag queue head.
- rsp_valid[i] = sum_valid & !empty & (head==i).
- sum_ready = !empty & rsp_ready[head].
- rsp_data = sum_data; rsp_id = head.
- Sums return in issue order, so the IDs are correct.
- sum_valid while empty: sum_ready=0, rsp_valid=0, err_orphan ← 1 and stays 1 until reset.

Widths: no arithmetic in this block. The sum passes through at W_DATA+1 bits unmodified.

Decomposition:
- Package a_plus_b_arb_pkg: state_t enum {IDLE, ISSUE, WAIT_A, WAIT_B}; ID-width helper function.
- Sub-module rr_arbiter (N):
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant, grant index, any_grant;
  - purely combinational.
- Tag queue, FSM and ptr register live inline in a_plus_b_arbiter.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with req_valid=4'hF and sum_valid=1 → req_ready=0, op_valid_a/b=0, rsp_valid=0, sum_ready=0, err_orphan=0.
2. Single pair: requester 2 sends a=200, b=100, all readies 1 → req_ready=4'b0100 at t. At t+1 op_data_a=200, op_data_b=100. Adder returns 9'd300 → rsp_valid=4'b0100, rsp_id=2, rsp_data=300, one pop.
3. Fairness: req_valid=4'hF held, ops and rsp always ready → grants 0,1,2,3,0,1; responses return with rsp_id in the same sequence and sums matching each requester's operands.
4. Skewed ready: op_ready_a=1, op_ready_b=0 for 3 cycles after ISSUE → a handshakes once, op_valid_a drops to 0. op_valid_b stays 1 with op_data_b stable, FSM in WAIT_B, req_ready=0 until b handshakes, then IDLE.
5. Tag full with D_TAG=2, sum_valid=0 → exactly 2 accepts, then req_ready=0 with requests pending. Return one sum → exactly one further accept. Also set rsp_ready[head]=0 with sum_valid=1 → sum_ready=0 and no pop.
6. Orphan: empty queue, sum_valid=1 for 1 cycle → sum_ready=0, rsp_valid=0, err_orphan=1 persisting through later traffic until rst=0.
